// File: rtl/receiver.sv
// 8N1 UART receiver oversampling at 16x baud via the clken_i tick.
// Define UART_RX_FRAME_CHECK_EN to reject frames whose stop bit is low.
module receiver (
  input  logic       clk_50m_i,
  input  logic       rst_n_i,
  input  logic       rx_i,
  input  logic       clken_i,
  input  logic       rdy_clr_i,
  output logic [7:0] dout_8b_o,
  output logic       rdy_o,
  output logic       rx_busy_o,
  output logic       frame_err_o,
  output logic       overrun_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  state_t     state_r, state_nxt_s;
  logic       rx_meta_r, rx_sync_r;
  logic [3:0] tick_cnt_r, tick_cnt_nxt_s;
  logic [2:0] bit_idx_r, bit_idx_nxt_s;
  logic [7:0] shift_r, shift_nxt_s;

  logic       stop_tick_s, accept_s, ferr_s;
  logic [7:0] dout_nxt_s;
  logic       rdy_nxt_s, ovr_nxt_s, busy_nxt_s;
  logic [7:0] dout_r;
  logic       rdy_r, ovr_r, busy_r, ferr_r;

  // Two-flop synchronizer; idles high so reset never looks like a start bit.
  always_ff @(posedge clk_50m_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
    end else begin
      rx_meta_r <= rx_i;
      rx_sync_r <= rx_meta_r;
    end
  end

  // FSM state, tick counter, bit index and data shift register.
  always_ff @(posedge clk_50m_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_r    <= ST_IDLE;
      tick_cnt_r <= 4'd0;
      bit_idx_r  <= 3'd0;
      shift_r    <= 8'h00;
    end else begin
      state_r    <= state_nxt_s;
      tick_cnt_r <= tick_cnt_nxt_s;
      bit_idx_r  <= bit_idx_nxt_s;
      shift_r    <= shift_nxt_s;
    end
  end

  // Next-state logic; everything holds while clken_i is low.
  always_comb begin
    state_nxt_s    = state_r;
    tick_cnt_nxt_s = tick_cnt_r;
    bit_idx_nxt_s  = bit_idx_r;
    shift_nxt_s    = shift_r;
    if (clken_i) begin
      case (state_r)
        ST_IDLE: begin
          if (!rx_sync_r) begin
            state_nxt_s    = ST_START;
            tick_cnt_nxt_s = 4'd0;
          end else begin
            state_nxt_s    = ST_IDLE;
          end
        end
        // Mid start bit: a high line here is a glitch, not a frame.
        ST_START: begin
          if (tick_cnt_r == 4'd7) begin
            tick_cnt_nxt_s = 4'd0;
            bit_idx_nxt_s  = 3'd0;
            if (rx_sync_r) begin
              state_nxt_s = ST_IDLE;
            end else begin
              state_nxt_s = ST_DATA;
            end
          end else begin
            tick_cnt_nxt_s = tick_cnt_r + 4'd1;
          end
        end
        ST_DATA: begin
          if (tick_cnt_r == 4'd15) begin
            tick_cnt_nxt_s         = 4'd0;
            shift_nxt_s[bit_idx_r] = rx_sync_r;
            if (bit_idx_r == 3'd7) begin
              state_nxt_s   = ST_STOP;
              bit_idx_nxt_s = 3'd0;
            end else begin
              bit_idx_nxt_s = bit_idx_r + 3'd1;
            end
          end else begin
            tick_cnt_nxt_s = tick_cnt_r + 4'd1;
          end
        end
        ST_STOP: begin
          if (tick_cnt_r == 4'd15) begin
            tick_cnt_nxt_s = 4'd0;
            state_nxt_s    = ST_IDLE;
          end else begin
            tick_cnt_nxt_s = tick_cnt_r + 4'd1;
          end
        end
        default: begin
          state_nxt_s    = ST_IDLE;
          tick_cnt_nxt_s = 4'd0;
          bit_idx_nxt_s  = 3'd0;
        end
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Output decode: frame acceptance and the next values of the flag registers.
  always_comb begin
    if (clken_i && (state_r == ST_STOP) && (tick_cnt_r == 4'd15)) begin
      stop_tick_s = 1'b1;
    end else begin
      stop_tick_s = 1'b0;
    end
`ifdef UART_RX_FRAME_CHECK_EN
    accept_s = stop_tick_s & rx_sync_r;
    ferr_s   = stop_tick_s & ~rx_sync_r;
`else
    accept_s = stop_tick_s;
    ferr_s   = 1'b0;
`endif
    if (accept_s) begin
      dout_nxt_s = shift_r;
      rdy_nxt_s  = 1'b1;
    end else if (rdy_clr_i) begin
      dout_nxt_s = dout_r;
      rdy_nxt_s  = 1'b0;
    end else begin
      dout_nxt_s = dout_r;
      rdy_nxt_s  = rdy_r;
    end
    // A clear on the acceptance edge means the consumer took the old byte.
    if (accept_s && rdy_r && !rdy_clr_i) begin
      ovr_nxt_s = 1'b1;
    end else if (rdy_clr_i) begin
      ovr_nxt_s = 1'b0;
    end else begin
      ovr_nxt_s = ovr_r;
    end
    busy_nxt_s = (state_nxt_s != ST_IDLE);
  end

  // Registered outputs.
  always_ff @(posedge clk_50m_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      dout_r <= 8'h00;
      rdy_r  <= 1'b0;
      ovr_r  <= 1'b0;
      busy_r <= 1'b0;
      ferr_r <= 1'b0;
    end else begin
      dout_r <= dout_nxt_s;
      rdy_r  <= rdy_nxt_s;
      ovr_r  <= ovr_nxt_s;
      busy_r <= busy_nxt_s;
      ferr_r <= ferr_s;
    end
  end

  assign dout_8b_o   = dout_r;
  assign rdy_o       = rdy_r;
  assign overrun_o   = ovr_r;
  assign rx_busy_o   = busy_r;
  assign frame_err_o = ferr_r;

endmodule

// File: tb/tb_receiver.sv
// Directed testbench for receiver: 8N1 frames with clken_i every 4th clock.
module tb_receiver;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx;
  logic       clken = 1'b0;
  logic       rdy_clr;
  logic [7:0] dout;
  logic       rdy, busy, ferr, ovr;

  int         nvec = 0;
  int         nerr = 0;
  int         ferr_cycles = 0;
  logic       ferr_prev = 1'b0;
  logic       ferr_long = 1'b0;
  logic [1:0] phase = 2'd0;
  logic       rdy_pre, rdy_post;

  receiver dut (
    .clk_50m_i   (clk),
    .rst_n_i     (rst_n),
    .rx_i        (rx),
    .clken_i     (clken),
    .rdy_clr_i   (rdy_clr),
    .dout_8b_o   (dout),
    .rdy_o       (rdy),
    .rx_busy_o   (busy),
    .frame_err_o (ferr),
    .overrun_o   (ovr)
  );

  always #10 clk = ~clk;

  // One-cycle sample tick every fourth clock.
  initial begin
    forever begin
      @(negedge clk);
      phase = phase + 2'd1;
      clken = (phase == 2'd3);
    end
  end

  // Frame-error pulse monitor: total high cycles and any pulse wider than one.
  always @(negedge clk) begin
    ferr_prev <= ferr;
    if (ferr) begin
      ferr_cycles <= ferr_cycles + 1;
    end
    if (ferr && ferr_prev) begin
      ferr_long <= 1'b1;
    end
  end

  task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%02h, expected 0x%02h", tag, got, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    repeat (n) begin
      do @(posedge clk); while (!clken);
    end
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk);
    rx = b;
    wait_ticks(16);
  endtask

  // Stop sample lands on tick 153 of the frame; optionally clear on that edge.
  task automatic send_frame(input logic [7:0] data, input logic stop_b, input logic clr_at_acc,
                            output logic pre, output logic post);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(data[i]);
    @(negedge clk);
    rx = stop_b;
    wait_ticks(8);
    repeat (3) @(posedge clk);
    @(negedge clk);
    pre     = rdy;
    rdy_clr = clr_at_acc;
    @(negedge clk);
    rdy_clr = 1'b0;
    post    = rdy;
    wait_ticks(7);
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    rdy_clr = 1'b1;
    @(negedge clk);
    rdy_clr = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst_n   = 1'b0;
    rx      = 1'b1;
    rdy_clr = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_dout", dout, 8'h00);
    check_val("rst_rdy", {7'd0, rdy}, 8'h00);
    check_val("rst_busy", {7'd0, busy}, 8'h00);
    check_val("rst_ferr", {7'd0, ferr}, 8'h00);
    check_val("rst_ovr", {7'd0, ovr}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    wait_ticks(4);

    // 0xA5, then clear
    send_frame(8'hA5, 1'b1, 1'b0, rdy_pre, rdy_post);
    check_val("a5_rdy_before_stop", {7'd0, rdy_pre}, 8'h00);
    check_val("a5_rdy_after_stop", {7'd0, rdy_post}, 8'h01);
    wait_ticks(4);
    @(negedge clk);
    check_val("a5_dout", dout, 8'hA5);
    check_val("a5_busy", {7'd0, busy}, 8'h00);
    check_val("a5_ovr", {7'd0, ovr}, 8'h00);
    pulse_clr();
    check_val("a5_clr_rdy", {7'd0, rdy}, 8'h00);
    check_val("a5_clr_dout", dout, 8'hA5);

    // Short low glitch: aborted in START
    wait_ticks(4);
    @(negedge clk);
    rx = 1'b0;
    wait_ticks(4);
    @(negedge clk);
    check_val("glitch_busy", {7'd0, busy}, 8'h01);
    rx = 1'b1;
    wait_ticks(16);
    @(negedge clk);
    check_val("glitch_busy_end", {7'd0, busy}, 8'h00);
    check_val("glitch_rdy", {7'd0, rdy}, 8'h00);
    check_val("glitch_dout", dout, 8'hA5);

    // Overrun: 0x3C left unread, then 0x81
    wait_ticks(4);
    send_frame(8'h3C, 1'b1, 1'b0, rdy_pre, rdy_post);
    wait_ticks(4);
    @(negedge clk);
    check_val("3c_dout", dout, 8'h3C);
    check_val("3c_ovr", {7'd0, ovr}, 8'h00);
    send_frame(8'h81, 1'b1, 1'b0, rdy_pre, rdy_post);
    wait_ticks(4);
    @(negedge clk);
    check_val("81_dout", dout, 8'h81);
    check_val("81_rdy", {7'd0, rdy}, 8'h01);
    check_val("81_ovr", {7'd0, ovr}, 8'h01);
    pulse_clr();
    check_val("81_clr_rdy", {7'd0, rdy}, 8'h00);
    check_val("81_clr_ovr", {7'd0, ovr}, 8'h00);

    // 0x55 with a low stop bit
    check_val("ferr_none_yet", 8'(ferr_cycles), 8'h00);
    wait_ticks(4);
    send_frame(8'h55, 1'b0, 1'b0, rdy_pre, rdy_post);
    @(negedge clk);
    rx = 1'b1;
    wait_ticks(32);
    @(negedge clk);
`ifdef UART_RX_FRAME_CHECK_EN
    check_val("bad_stop_ferr_cycles", 8'(ferr_cycles), 8'h01);
    check_val("bad_stop_rdy", {7'd0, rdy}, 8'h00);
    check_val("bad_stop_dout", dout, 8'h81);
`else
    check_val("bad_stop_ferr_cycles", 8'(ferr_cycles), 8'h00);
    check_val("bad_stop_rdy", {7'd0, rdy}, 8'h01);
    check_val("bad_stop_dout", dout, 8'h55);
`endif
    check_val("ferr_width", {7'd0, ferr_long}, 8'h00);
    pulse_clr();

    // Reset in the middle of bit 4 of 0xF0, then 0x0F
    wait_ticks(4);
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b0);
    @(negedge clk);
    rx = 1'b1;
    wait_ticks(8);
    @(negedge clk);
    check_val("f0_busy", {7'd0, busy}, 8'h01);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_dout", dout, 8'h00);
    check_val("mid_rst_busy", {7'd0, busy}, 8'h00);
    check_val("mid_rst_rdy", {7'd0, rdy}, 8'h00);
    check_val("mid_rst_ovr", {7'd0, ovr}, 8'h00);
    check_val("mid_rst_ferr", {7'd0, ferr}, 8'h00);
    wait_ticks(4);
    @(negedge clk);
    rst_n = 1'b1;
    wait_ticks(4);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    wait_ticks(16);
    @(negedge clk);
    check_val("post_rst_rdy", {7'd0, rdy}, 8'h00);
    check_val("post_rst_busy", {7'd0, busy}, 8'h00);
    check_val("post_rst_dout", dout, 8'h00);
    send_frame(8'h0F, 1'b1, 1'b0, rdy_pre, rdy_post);
    wait_ticks(4);
    @(negedge clk);
    check_val("0f_dout", dout, 8'h0F);
    check_val("0f_rdy", {7'd0, rdy}, 8'h01);
    check_val("0f_ovr", {7'd0, ovr}, 8'h00);

    // 0x12 completes on the same edge as a clear while rdy_o is high
    send_frame(8'h12, 1'b1, 1'b1, rdy_pre, rdy_post);
    check_val("12_rdy_pre", {7'd0, rdy_pre}, 8'h01);
    check_val("12_rdy_post", {7'd0, rdy_post}, 8'h01);
    wait_ticks(4);
    @(negedge clk);
    check_val("12_dout", dout, 8'h12);
    check_val("12_rdy", {7'd0, rdy}, 8'h01);
    check_val("12_ovr", {7'd0, ovr}, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/receiver.md
RECEIVER -- requirements
Module: receiver

Interface
REQ-001 SHALL have clk_50m_i  input  1  system clock; all state changes on its rising edge.
REQ-002 SHALL have rst_n_i  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have rx_i  input  1  serial line, idle high, asynchronous to clk_50m_i.
REQ-004 SHALL have clken_i  input  1  one-cycle sample tick at 16x baud rate.
REQ-005 SHALL have rdy_clr_i  input  1  consumer acknowledge; clears rdy_o and overrun_o.
REQ-006 SHALL have dout_8b_o  output  8  last received byte.
REQ-007 SHALL have rdy_o  output  1  byte available, held until cleared.
REQ-008 SHALL have rx_busy_o  output  1  high whenever the FSM is not IDLE.
REQ-009 SHALL have frame_err_o  output  1  one-cycle pulse on a bad stop bit.
REQ-010 SHALL have overrun_o  output  1  sticky flag: a byte completed while rdy_o was high.

Function
REQ-011 SHALL pass rx_i through a 2-flop synchronizer (reset value 1); all decisions use the synchronized value.
REQ-012 SHALL implement a 4-state FSM: IDLE, START, DATA, STOP; a 4-bit tick counter; a 3-bit bit index.
REQ-013 IDLE: on clken_i with synced rx=0 -> START, tick counter cleared.
REQ-014 START: count clken_i ticks; on the 8th tick sample rx: 0 -> DATA with counter and bit index cleared; 1 -> IDLE (glitch rejected, no flags).
REQ-015 DATA: every 16th clken_i tick sample rx into the bit at the bit index, LSB first; after bit 7 -> STOP with counter cleared.
REQ-016 STOP: on the 16th clken_i tick sample rx: 1 -> frame accepted; 0 -> frame error; both -> IDLE.
REQ-017 On an accepted frame, SHALL load dout_8b_o and set rdy_o on the clk_50m_i edge after the stop-sample tick.
REQ-018 dout_8b_o SHALL change only when a frame is accepted.
REQ-019 rdy_o SHALL stay high until rdy_clr_i is sampled high; rdy_clr_i with rdy_o low SHALL be a no-op.
REQ-020 A frame accepted while rdy_o=1 and rdy_clr_i=0 SHALL overwrite dout_8b_o and set overrun_o.
REQ-021 Frame acceptance coincident with rdy_clr_i=1: rdy_o stays 1, overrun_o not set, new byte presented.
REQ-022 overrun_o SHALL clear on rdy_clr_i unless REQ-020 sets it in the same cycle, in which case set wins.
REQ-023 Ticks SHALL be counted only on clk_50m_i edges with clken_i=1; clken_i low SHALL freeze the FSM and counters.
REQ-024 Line activity during DATA/STOP SHALL NOT restart the frame; the next start bit is searched only from IDLE.

Reset
REQ-025 Reset, asynchronous and at any point including mid-frame, SHALL force: FSM IDLE; counters 0; synchronizer 1; dout_8b_o=0x00; rdy_o, rx_busy_o, frame_err_o, overrun_o = 0.
REQ-026 After reset release, SHALL wait for a fresh falling edge; a partially received frame SHALL NOT be reported.

Configuration
REQ-027 Macro UART_RX_FRAME_CHECK_EN selects stop-bit checking.
- Defined: a bad stop bit pulses frame_err_o for one cycle; dout_8b_o, rdy_o and overrun_o are unchanged.
- Undefined: the stop bit is not checked; every frame reaching STOP is accepted per REQ-017; frame_err_o is tied 0.

Verification
REQ-028 Send 0xA5 as 8N1 at 16x ticks, then pulse rdy_clr_i -> dout_8b_o=0xA5, rdy_o=1 one cycle after the stop sample, rx_busy_o low after; rdy_o=0 after the clear.
REQ-029 rx_i low for 4 ticks, then high -> START aborts to IDLE; rdy_o=0, dout_8b_o unchanged.
REQ-030 Send 0x3C with no clear, then 0x81 -> dout_8b_o=0x81, overrun_o=1; rdy_clr_i clears both flags.
REQ-031 Send 0x55 with stop bit 0 -> with UART_RX_FRAME_CHECK_EN: frame_err_o one-cycle pulse, rdy_o=0. Without it: dout_8b_o=0x55, rdy_o=1.
REQ-032 Assert rst_n_i low during bit 4 of 0xF0, release, then send 0x0F -> only 0x0F is reported; all outputs 0 during reset.
REQ-033 rdy_clr_i on the same edge as 0x12 completion while rdy_o=1 -> rdy_o=1, overrun_o=0, dout_8b_o=0x12.
